// File: rtl/tag_lookup_unit_if.sv
// Request/response channel of tag_lookup_unit: request handshake plus one-cycle response strobe.
// The master drives requests; the slave (tag_lookup_unit) answers.
interface tag_lookup_unit_if #(
   parameter int NUMBER_OF_WAYS = 4,
   parameter int INDEX_BITS     = 8,
   parameter int TAG_BITS       = 20
);
   localparam int WAY_BITS = $clog2(NUMBER_OF_WAYS);

   logic                      req_valid;
   logic                      req_ready;
   logic [1:0]                req_op;
   logic [INDEX_BITS-1:0]     req_index;
   logic [TAG_BITS-1:0]       req_tag;
   logic [NUMBER_OF_WAYS-1:0] fill_way;
   logic                      resp_valid;
   logic                      resp_hit;
   logic [WAY_BITS-1:0]       resp_way;

   modport master (
      output req_valid, req_op, req_index, req_tag, fill_way,
      input  req_ready, resp_valid, resp_hit, resp_way
   );

   modport slave (
      input  req_valid, req_op, req_index, req_tag, fill_way,
      output req_ready, resp_valid, resp_hit, resp_way
   );
endinterface

// File: rtl/tag_lookup_unit.sv
// Set-associative tag store with lookup/fill/invalidate; feeds replacement_controller.
// Optional `define LOOKUP_STATS_EN adds saturating lookup hit/miss counters.
module tag_lookup_unit #(
   parameter int NUMBER_OF_WAYS = 4,
   parameter int INDEX_BITS     = 8,
   parameter int TAG_BITS       = 20,
   parameter int STAT_BITS      = 32
) (
   input  logic                                 clock,
   input  logic                                 reset,
   tag_lookup_unit_if.slave                     bus,
   output logic [INDEX_BITS-1:0]                current_index,
   output logic [NUMBER_OF_WAYS-1:0]            ways_in_use,
   output logic [$clog2(NUMBER_OF_WAYS)-1:0]    current_access,
   output logic                                 access_valid
`ifdef LOOKUP_STATS_EN
   ,
   output logic [STAT_BITS-1:0]                 hit_count,
   output logic [STAT_BITS-1:0]                 miss_count
`endif
);
   localparam int WAY_BITS = $clog2(NUMBER_OF_WAYS);
   localparam int SETS     = 1 << INDEX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_e;
   typedef enum logic [1:0] {
      OP_LOOKUP     = 2'b00,
      OP_FILL       = 2'b01,
      OP_INVALIDATE = 2'b10,
      OP_LOOKUP_ALT = 2'b11
   } op_e;

   state_e                    state;
   op_e                       op_q;
   logic [INDEX_BITS-1:0]     index_q;
   logic [TAG_BITS-1:0]       tag_q;
   logic [NUMBER_OF_WAYS-1:0] fill_way_q;

   logic [NUMBER_OF_WAYS-1:0] valid_bits [SETS];
   logic [TAG_BITS-1:0]       tag_mem    [SETS][NUMBER_OF_WAYS];

   logic [NUMBER_OF_WAYS-1:0] set_valid;
   logic [NUMBER_OF_WAYS-1:0] match_vec;
   logic [WAY_BITS-1:0]       match_way;
   logic [WAY_BITS-1:0]       write_way;
   logic [NUMBER_OF_WAYS-1:0] next_valid;
   logic [WAY_BITS-1:0]       next_way;
   logic                      next_hit;
   logic                      next_access;
   logic                      tag_write;

   function automatic logic [WAY_BITS-1:0] lowest_way(input logic [NUMBER_OF_WAYS-1:0] vec);
      lowest_way = '0;
      for (int w = NUMBER_OF_WAYS - 1; w >= 0; w--) begin
         if (vec[WAY_BITS'(w)]) lowest_way = WAY_BITS'(w);
      end
   endfunction

   always_comb begin
      set_valid = valid_bits[index_q];
      match_vec = '0;
      for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
         match_vec[WAY_BITS'(w)] = set_valid[WAY_BITS'(w)] &&
                                   (tag_mem[index_q][WAY_BITS'(w)] == tag_q);
      end
      match_way = lowest_way(match_vec);
      write_way = lowest_way(fill_way_q);
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      next_valid  = set_valid;
      next_way    = '0;
      next_hit    = 1'b0;
      next_access = 1'b0;
      tag_write   = 1'b0;
      case (op_q)
         OP_FILL: begin
            if (|match_vec) begin
               next_hit    = 1'b1;
               next_way    = match_way;
               next_access = 1'b1;
            end else if (|fill_way_q) begin
               next_hit              = 1'b1;
               next_way              = write_way;
               next_access           = 1'b1;
               next_valid[write_way] = 1'b1;
               tag_write             = 1'b1;
            end
         end
         OP_INVALIDATE: begin
            if (|match_vec) begin
               next_hit              = 1'b1;
               next_way              = match_way;
               next_valid[match_way] = 1'b0;
            end
         end
         default: begin
            if (|match_vec) begin
               next_hit    = 1'b1;
               next_way    = match_way;
               next_access = 1'b1;
            end
         end
      endcase
   end

   // NOTE: tag storage is intentionally not reset; valid bits alone decide whether a tag counts.
   always_ff @(posedge clock) begin
      if (reset && state == S_LOOKUP && tag_write) begin
         tag_mem[index_q][write_way] <= tag_q;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= S_IDLE;
         op_q           <= OP_LOOKUP;
         index_q        <= '0;
         tag_q          <= '0;
         fill_way_q     <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_hit   <= 1'b0;
         bus.resp_way   <= '0;
         current_index  <= '0;
         ways_in_use    <= '0;
         current_access <= '0;
         access_valid   <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_bits[INDEX_BITS'(s)] <= '0;
         end
`ifdef LOOKUP_STATS_EN
         hit_count      <= '0;
         miss_count     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  op_q          <= op_e'(bus.req_op);
                  index_q       <= bus.req_index;
                  tag_q         <= bus.req_tag;
                  fill_way_q    <= bus.fill_way;
                  bus.req_ready <= 1'b0;
                  state         <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               valid_bits[index_q] <= next_valid;
               bus.resp_valid      <= 1'b1;
               bus.resp_hit        <= next_hit;
               bus.resp_way        <= next_way;
               current_access      <= next_way;
               access_valid        <= next_access;
               current_index       <= index_q;
               ways_in_use         <= next_valid;
               state               <= S_RESP;
            end
            S_RESP: begin
               bus.resp_valid <= 1'b0;
               access_valid   <= 1'b0;
               bus.req_ready  <= 1'b1;
               state          <= S_IDLE;
`ifdef LOOKUP_STATS_EN
               // Only lookups are counted; both lookup encodings qualify.
               if (op_q == OP_LOOKUP || op_q == OP_LOOKUP_ALT) begin
                  if (bus.resp_hit) begin
                     if (hit_count != '1) hit_count <= hit_count + 1'b1;
                  end else begin
                     if (miss_count != '1) miss_count <= miss_count + 1'b1;
                  end
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tag_lookup_unit.sv
// Scoreboard bench for tag_lookup_unit: directed scenarios plus random ops against a set/way model.
module tb_tag_lookup_unit;
   localparam int WAYS  = 4;
   localparam int IDXB  = 8;
   localparam int TAGB  = 20;
   localparam int STATB = 32;
   localparam int WB    = $clog2(WAYS);
   localparam int SETS  = 1 << IDXB;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   tag_lookup_unit_if #(.NUMBER_OF_WAYS(WAYS), .INDEX_BITS(IDXB), .TAG_BITS(TAGB)) bus ();

   logic [IDXB-1:0] current_index;
   logic [WAYS-1:0] ways_in_use;
   logic [WB-1:0]   current_access;
   logic            access_valid;
`ifdef LOOKUP_STATS_EN
   logic [STATB-1:0] hit_count;
   logic [STATB-1:0] miss_count;
`endif

   tag_lookup_unit #(
      .NUMBER_OF_WAYS(WAYS), .INDEX_BITS(IDXB), .TAG_BITS(TAGB), .STAT_BITS(STATB)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .current_index (current_index),
      .ways_in_use   (ways_in_use),
      .current_access(current_access),
      .access_valid  (access_valid)
`ifdef LOOKUP_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   typedef struct {
      logic            hit;
      logic [WB-1:0]   way;
      logic            acc;
      logic [WAYS-1:0] wiu;
      logic [IDXB-1:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   accept_q[$];
   int   ncyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: which ways of each set hold which tag.
   bit              mv [SETS][WAYS];
   logic [TAGB-1:0] mt [SETS][WAYS];
   longint          m_hits;
   longint          m_misses;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic model_apply(input logic [1:0] op, input int idx, input logic [TAGB-1:0] tag,
                              input logic [WAYS-1:0] fw, output exp_t e);
      int m = -1;
      int f = -1;
      for (int w = 0; w < WAYS; w++)
         if (m < 0 && mv[idx][w] && mt[idx][w] == tag) m = w;
      for (int w = 0; w < WAYS; w++)
         if (f < 0 && fw[w]) f = w;
      e.hit = 1'b0; e.way = '0; e.acc = 1'b0;
      if (op == 2'b01) begin
         if (m >= 0) begin
            e.hit = 1'b1; e.way = WB'(m); e.acc = 1'b1;
         end else if (f >= 0) begin
            mv[idx][f] = 1'b1; mt[idx][f] = tag;
            e.hit = 1'b1; e.way = WB'(f); e.acc = 1'b1;
         end
      end else if (op == 2'b10) begin
         if (m >= 0) begin
            mv[idx][m] = 1'b0;
            e.hit = 1'b1; e.way = WB'(m);
         end
      end else begin
         if (m >= 0) begin
            e.hit = 1'b1; e.way = WB'(m); e.acc = 1'b1; m_hits++;
         end else begin
            m_misses++;
         end
      end
      for (int w = 0; w < WAYS; w++) e.wiu[w] = mv[idx][w];
      e.idx = IDXB'(idx);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [1:0] op, input int idx, input logic [TAGB-1:0] tag,
                        input logic [WAYS-1:0] fw, input bit keep, input bit spacing,
                        input bit expect_resp);
      int   waits = 0;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_index = IDXB'(idx);
      bus.req_tag   = tag;
      bus.fill_way  = fw;
      do begin
         @(negedge clock);
         waits++;
      end while (!bus.req_ready && waits < 50);
      if (!bus.req_ready) begin
         check("req_ready_within_bound", bus.req_ready, 1);
         bus.req_valid = 1'b0;
         return;
      end
      if (spacing) check("accept_spacing", waits, 3);
      if (expect_resp) begin
         model_apply(op, idx, tag, fw, e);
         exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
      if (!keep) bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("responses_drained", exp_q.size(), 0);
      @(posedge clock);
      #1;
   endtask

   task automatic reset_checks();
      @(negedge clock);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_hit", bus.resp_hit, 0);
      check("rst_ways_in_use", ways_in_use, 0);
      check("rst_current_index", current_index, 0);
      check("rst_access_valid", access_valid, 0);
`ifdef LOOKUP_STATS_EN
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
`endif
      @(posedge clock);
      #1;
   endtask

`ifdef LOOKUP_STATS_EN
   task automatic stats_checks();
      @(negedge clock);
      check("hit_count", hit_count, 64'(m_hits));
      check("miss_count", miss_count, 64'(m_misses));
      @(posedge clock);
      #1;
   endtask
`endif

   // Monitor: detects accepts and pops the scoreboard on every response strobe.
   initial begin
      exp_t e;
      int   a;
      forever begin
         @(negedge clock);
         ncyc++;
         if (reset && bus.req_valid && bus.req_ready) accept_q.push_back(ncyc);
         if (bus.resp_valid) begin
            if (exp_q.size() == 0 || accept_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               a = accept_q.pop_front();
               check("resp_latency", ncyc - a, 2);
               check("resp_hit", bus.resp_hit, e.hit);
               check("resp_way", bus.resp_way, e.way);
               check("current_access", current_access, e.way);
               check("access_valid", access_valid, e.acc);
               check("ways_in_use", ways_in_use, e.wiu);
               check("current_index", current_index, e.idx);
            end
         end else if (access_valid) begin
            check("access_valid_outside_resp", access_valid, 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit prev_keep;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_index = '0;
      bus.req_tag   = '0;
      bus.fill_way  = '0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      reset_checks();

      // Lookup into an empty set, then fill and hit.
      issue(2'b00, 1, 20'h00ABC, 4'b0000, 0, 0, 1);
      issue(2'b01, 1, 20'h00ABC, 4'b0001, 0, 0, 1);
      issue(2'b00, 1, 20'h00ABC, 4'b0000, 0, 0, 1);

      // Fill remaining ways, then a refill of an existing tag must reuse its way.
      issue(2'b01, 1, 20'h00001, 4'b0010, 0, 0, 1);
      issue(2'b01, 1, 20'h00002, 4'b0100, 0, 0, 1);
      issue(2'b01, 1, 20'h00003, 4'b1000, 0, 0, 1);
      issue(2'b01, 1, 20'h00002, 4'b0001, 0, 0, 1);
      issue(2'b00, 1, 20'h00ABC, 4'b0000, 0, 0, 1);

      // Invalidate hit, then repeat as a miss.
      issue(2'b10, 1, 20'h00002, 4'b0000, 0, 0, 1);
      issue(2'b10, 1, 20'h00002, 4'b0000, 0, 0, 1);

      // Fill with no target way, then back-to-back requests with req_valid held high.
      issue(2'b01, 1, 20'h00055, 4'b0000, 0, 0, 1);
      issue(2'b00, 1, 20'h00055, 4'b0000, 1, 0, 1);
      issue(2'b11, 1, 20'h00003, 4'b0000, 1, 1, 1);
      issue(2'b01, 2, 20'h00009, 4'b0110, 1, 1, 1);
      issue(2'b00, 2, 20'h00009, 4'b0000, 0, 1, 1);
      wait_drain();

      // Reset while a fill is in its lookup cycle: no response, nothing written.
      issue(2'b01, 3, 20'h00777, 4'b0001, 0, 0, 0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      exp_q.delete();
      accept_q.delete();
      reset_checks();
      issue(2'b00, 3, 20'h00777, 4'b0000, 0, 0, 1);
      issue(2'b00, 1, 20'h00ABC, 4'b0000, 0, 0, 1);
      wait_drain();
      model_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      reset_checks();

      // Two lookup hits and one lookup miss for the statistics counters.
      issue(2'b01, 5, 20'h00007, 4'b0100, 0, 0, 1);
      issue(2'b00, 5, 20'h00007, 4'b0000, 0, 0, 1);
      issue(2'b11, 5, 20'h00007, 4'b0000, 0, 0, 1);
      issue(2'b00, 5, 20'h00008, 4'b0000, 0, 0, 1);
      wait_drain();
`ifdef LOOKUP_STATS_EN
      stats_checks();
`endif

      // Random traffic over a few sets and a small tag space to force collisions.
      prev_keep = 1'b0;
      for (int i = 0; i < 300; i++) begin
         logic [1:0]      op;
         int              idx;
         logic [TAGB-1:0] tag;
         logic [WAYS-1:0] fw;
         bit              keep;
         op   = 2'($urandom_range(0, 3));
         idx  = int'($urandom_range(0, 3));
         tag  = TAGB'($urandom_range(0, 7));
         fw   = ($urandom_range(0, 3) == 0) ? WAYS'(1 << $urandom_range(0, WAYS - 1))
                                            : WAYS'($urandom_range(0, 15));
         keep = ($urandom_range(0, 3) == 0);
         issue(op, idx, tag, fw, keep, prev_keep, 1);
         prev_keep = keep;
      end
      bus.req_valid = 1'b0;
      wait_drain();
`ifdef LOOKUP_STATS_EN
      stats_checks();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
